ad7124_responder: RTL and testbench
===================================

Name: ad7124_responder

Overview:
- Synthesizable SPI responder that emulates the AD7124 serial interface: comms register, status, ADC control, data and ID registers.
- Used as the far end of the ADC read master for on-FPGA loopback, and as a bench model.
- Serves samples pushed on a parallel port to any master issuing AD7124 register reads.
- Runs in the clk domain and oversamples the SPI pins, which are asynchronous to clk.

Parameters:
- ID_VALUE, 8'h14, value returned by the ID register (addr 0x05).
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk/cs/sdi (legal range 2..3).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from master, mode 3 (idles high).
- cs  in  1  SPI chip select from master, active low.
- sdi  in  1  SPI MOSI.
- sdo  out  1  SPI MISO (DOUT/RDY).
- sdo_t  out  1  tristate control for sdo; 1 = high-Z.
- sample  in  24  new conversion result.
- sample_valid  in  1  one-cycle strobe loading sample.
- ctrl_reg  out  16  ADC control register contents.
- ctrl_wr  out  1  one-cycle pulse when ctrl_reg is written.
- rd_done  out  1  one-cycle pulse after the last data-register bit has been shifted out.
- overrun  out  1  one-cycle pulse when sample_valid arrives while the previous sample is unread.

Behaviour:
- Reset: sdo=1, sdo_t=1, ctrl_reg=16'h0000, ctrl_wr=0, rd_done=0, overrun=0, rdy=0, ovr_sticky=0, pending=0, state=IDLE.
- Synchronization and timing:
  - sclk, cs and sdi each pass through SYNC_STAGES flip-flops.
  - One extra register provides rise/fall detection.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
  - The master must keep each sclk half-period at 4 clk or more.
- SPI mode 3:
  - sdi is sampled on a detected sclk rise.
  - sdo is updated on a detected sclk fall.
  - Bits are MSB first.
- sdo_t = synced cs; it goes high-Z within SYNC_STAGES+1 clk of cs rising.
- Data holding:
  - On sample_valid: pending <= sample; rdy <= 1.
  - If rdy was already 1: overrun pulses and ovr_sticky <= 1.
- Status register, 8 bits: {~rdy, ovr_sticky, 6'b0}.
- Register map, by address and width:
  - 0x00 status, 8 bits, read-only; reading it clears ovr_sticky at decode.
  - 0x01 control, 16 bits, read/write.
  - 0x02 data, 24 bits, read-only.
  - 0x05 ID, 8 bits, reads ID_VALUE.
  - All other addresses: 8 bits, read as 0, writes ignored.
- State machine:
  - IDLE: sdo=1. On synced cs falling -> CMD with bitcnt=0.
  - CMD:
    - sdo = ~rdy, live DOUT/RDY.
    - Shift 8 sdi bits in; bit7=WEN, bit6=R/W (1 = read), bits5:0 = address.
    - On the 8th rise, decode. If WEN=1 -> IGNORE.
    - If read: load shift-out register, left-aligned, with the register value and go to RD.
      - For the data register: the snapshot is pending and rdy is cleared at decode.
      - If sample_valid coincides with decode, the snapshot takes the old pending, the new sample is stored, and rdy stays 1.
    - If write: go to WR.
  - RD: on each fall, sdo <= next bit (first bit on the fall after the 8th rise). After the width-th bit is driven and its rise is seen, go to CMD; pulse rd_done if the address was 0x02.
  - WR: shift width bits of sdi. On the last rise: if address 0x01, ctrl_reg <= shifted value and pulse ctrl_wr. Then go to CMD.
  - IGNORE: sdo=1, all traffic discarded until cs rises.
- cs rising in any state:
  - Go to IDLE.
  - Any partial write is discarded; no ctrl_wr.
  - A partial data read gives no rd_done, but rdy stays cleared.
- The bit counter restarts on every entry to CMD, so back-to-back commands within one cs-low period are legal.
- Reset mid-transfer returns everything to reset values. Operation resumes at the next cs falling edge; a cs already low is not treated as a transaction start.

Test Plan:
- Data read: sample=24'hA5C3F0, sample_valid pulse; master sends cs low + 8'h42, then 24 clocks (8-clk half-periods) -> MISO=A5C3F0 MSB first, rd_done pulses once, status then reads 8'h80 (RDY_n=1).
- RDY line: before any sample, CMD-phase sdo=1; after sample_valid, sdo=0 within one clk while cs low and in CMD.
- Control write: 8'h01 then 16'h0480 -> ctrl_wr pulses once, ctrl_reg=16'h0480; read back with 8'h41 -> MISO=16'h0480.
- Overrun: two sample_valid strobes (0x000001, 0x000002) with no read -> overrun pulses once, data read returns 0x000002, status read returns 8'hC0, a second status read returns 8'h80.
- Abort: write 8'h01 + 10 bits then cs high -> no ctrl_wr, ctrl_reg unchanged, sdo_t=1; a following transaction to ID (8'h45) returns 8'h14.
- Edge cases:
  - WEN=1 command (8'hC2): sdo stays 1 for the rest of cs-low, with no rd_done.
  - sample_valid on the decode cycle of a data read: old value returned, rdy remains 1.

Source files
------------

// File: rtl/ad7124_responder.sv
// AD7124-style SPI responder: comms/status/control/data/ID registers served
// from the clk domain by oversampling an SPI mode-3 master.
module ad7124_responder #(
  parameter logic [7:0] ID_VALUE    = 8'h14,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_sdi,
  output logic        o_sdo,
  output logic        o_sdo_t,
  input  logic [23:0] i_sample,
  input  logic        i_sample_valid,
  output logic [15:0] o_ctrl_reg,
  output logic        o_ctrl_wr,
  output logic        o_rd_done,
  output logic        o_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);

  // Register width in bits for a given address (unmapped addresses are 8 bits).
  function automatic logic [5:0] reg_width(input logic [5:0] addr);
    logic [5:0] w;
    case (addr)
      6'h01:   w = 6'd16;
      6'h02:   w = 6'd24;
      default: w = 6'd8;
    endcase
    return w;
  endfunction

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync;
  logic        r_sclk_d, r_cs_d, r_cs_armed, r_sdo_t;
  logic [1:0]  r_fill_cnt;
  logic        w_sclk_s, w_cs_s, w_sdi_s, w_fill_done;
  logic        w_sclk_rise, w_sclk_fall, w_cs_fall;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_bitcnt, w_bitcnt_nxt;
  logic [5:0]  r_addr, w_addr_nxt;
  logic [14:0] r_shift_in, w_shift_in_nxt;
  logic [23:0] r_shift_out, w_shift_out_nxt;
  logic [15:0] r_ctrl_reg, w_ctrl_nxt;
  logic        r_ctrl_wr, w_ctrl_wr_nxt;
  logic        r_rd_done, w_rd_done_nxt;
  logic        r_overrun, w_overrun_nxt;
  logic        r_rdy, w_rdy_nxt;
  logic        r_ovr_sticky, w_ovr_nxt;
  logic [23:0] r_pending, w_pending_nxt;
  logic        r_sdo, w_sdo_nxt;

  logic        w_take, w_ovr_clr, w_drive, w_rdy_kept, w_ovr_kept;
  logic [7:0]  w_cmd_byte, w_status;
  logic [15:0] w_wr_val;
  logic [23:0] w_rd_value;
  logic [5:0]  w_width;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_fill_done = (r_fill_cnt == FILL_DONE);
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  // A cs already low out of reset must not start a transaction, so a fall
  // only counts once cs has been seen high with a fully refilled chain.
  assign w_cs_fall   = r_cs_armed & r_cs_d & ~w_cs_s;

  assign w_cmd_byte  = {r_shift_in[6:0], w_sdi_s};
  assign w_wr_val    = {r_shift_in[14:0], w_sdi_s};
  assign w_status    = {~r_rdy, r_ovr_sticky, 6'b000000};
  assign w_width     = reg_width(r_addr);

  // Left-aligned read value for the address carried by the command byte.
  always_comb begin
    case (w_cmd_byte[5:0])
      6'h00:   w_rd_value = {w_status, 16'h0000};
      6'h01:   w_rd_value = {r_ctrl_reg, 8'h00};
      6'h02:   w_rd_value = r_pending;
      6'h05:   w_rd_value = {ID_VALUE, 16'h0000};
      default: w_rd_value = 24'h000000;
    endcase
  end

  // Pin synchronizers, edge-detect history and cs arming.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sclk_sync <= {SYNC_STAGES{1'b1}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_sdi_sync  <= {SYNC_STAGES{1'b0}};
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b1;
      r_fill_cnt  <= 2'd0;
      r_cs_armed  <= 1'b0;
      r_sdo_t     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      r_fill_cnt  <= w_fill_done ? r_fill_cnt : r_fill_cnt + 2'd1;
      r_cs_armed  <= r_cs_armed | (w_fill_done & w_cs_s);
      r_sdo_t     <= w_cs_s;
    end
  end

  // Protocol FSM next-state and shift/counter datapath.
  always_comb begin
    w_state_nxt     = r_state;
    w_bitcnt_nxt    = r_bitcnt;
    w_addr_nxt      = r_addr;
    w_shift_in_nxt  = r_shift_in;
    w_shift_out_nxt = r_shift_out;
    w_ctrl_nxt      = r_ctrl_reg;
    w_ctrl_wr_nxt   = 1'b0;
    w_rd_done_nxt   = 1'b0;
    w_take          = 1'b0;
    w_ovr_clr       = 1'b0;
    w_drive         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt  = ST_CMD;
          w_bitcnt_nxt = 6'd0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_in_nxt = {r_shift_in[13:0], w_sdi_s};
          if (r_bitcnt == 6'd7) begin
            w_bitcnt_nxt = 6'd0;
            w_addr_nxt   = w_cmd_byte[5:0];
            if (w_cmd_byte[7]) begin
              w_state_nxt = ST_IGNORE;
            end else if (w_cmd_byte[6]) begin
              w_state_nxt     = ST_RD;
              w_shift_out_nxt = w_rd_value;
              w_ovr_clr       = (w_cmd_byte[5:0] == 6'h00);
              w_take          = (w_cmd_byte[5:0] == 6'h02);
            end else begin
              w_state_nxt = ST_WR;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + 6'd1;
          end
        end else begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_RD: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_fall && (r_bitcnt != w_width)) begin
          w_drive         = 1'b1;
          w_shift_out_nxt = {r_shift_out[22:0], 1'b0};
          w_bitcnt_nxt    = r_bitcnt + 6'd1;
        end else if (w_sclk_rise && (r_bitcnt == w_width)) begin
          w_state_nxt   = ST_CMD;
          w_bitcnt_nxt  = 6'd0;
          w_rd_done_nxt = (r_addr == 6'h02);
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_WR: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_in_nxt = {r_shift_in[13:0], w_sdi_s};
          if (r_bitcnt == (w_width - 6'd1)) begin
            w_state_nxt   = ST_CMD;
            w_bitcnt_nxt  = 6'd0;
            w_ctrl_wr_nxt = (r_addr == 6'h01);
            w_ctrl_nxt    = (r_addr == 6'h01) ? w_wr_val : r_ctrl_reg;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 6'd1;
          end
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      ST_IGNORE: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IGNORE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sample holding: a data-read decode consumes rdy before a coincident sample lands.
  always_comb begin
    w_rdy_kept = r_rdy & ~w_take;
    w_ovr_kept = r_ovr_sticky & ~w_ovr_clr;
    if (i_sample_valid) begin
      w_pending_nxt = i_sample;
      w_rdy_nxt     = 1'b1;
      w_overrun_nxt = w_rdy_kept;
      w_ovr_nxt     = w_ovr_kept | w_rdy_kept;
    end else begin
      w_pending_nxt = r_pending;
      w_rdy_nxt     = w_rdy_kept;
      w_overrun_nxt = 1'b0;
      w_ovr_nxt     = w_ovr_kept;
    end
  end

  // MISO source: live ~RDY in CMD, shifted data in RD, idle-high otherwise.
  always_comb begin
    case (w_state_nxt)
      ST_CMD: w_sdo_nxt = ~w_rdy_nxt;
      ST_RD: begin
        if (w_drive) begin
          w_sdo_nxt = r_shift_out[23];
        end else begin
          w_sdo_nxt = r_sdo;
        end
      end
      default: w_sdo_nxt = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_bitcnt     <= 6'd0;
      r_addr       <= 6'd0;
      r_shift_in   <= 15'd0;
      r_shift_out  <= 24'd0;
      r_ctrl_reg   <= 16'h0000;
      r_ctrl_wr    <= 1'b0;
      r_rd_done    <= 1'b0;
      r_overrun    <= 1'b0;
      r_rdy        <= 1'b0;
      r_ovr_sticky <= 1'b0;
      r_pending    <= 24'd0;
      r_sdo        <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_addr       <= w_addr_nxt;
      r_shift_in   <= w_shift_in_nxt;
      r_shift_out  <= w_shift_out_nxt;
      r_ctrl_reg   <= w_ctrl_nxt;
      r_ctrl_wr    <= w_ctrl_wr_nxt;
      r_rd_done    <= w_rd_done_nxt;
      r_overrun    <= w_overrun_nxt;
      r_rdy        <= w_rdy_nxt;
      r_ovr_sticky <= w_ovr_nxt;
      r_pending    <= w_pending_nxt;
      r_sdo        <= w_sdo_nxt;
    end
  end

  assign o_sdo      = r_sdo;
  assign o_sdo_t    = r_sdo_t;
  assign o_ctrl_reg = r_ctrl_reg;
  assign o_ctrl_wr  = r_ctrl_wr;
  assign o_rd_done  = r_rd_done;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_ad7124_responder.sv
// Bench for ad7124_responder: SPI mode-3 master tasks, a register-map
// reference model, and a monitor that scores MISO words and output pulses.
module tb_ad7124_responder;
  localparam int         H    = 8;
  localparam int         SYNC = 2;
  localparam logic [7:0] ID   = 8'h14;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        i_sclk = 1'b1, i_cs = 1'b1, i_sdi = 1'b0;
  logic [23:0] i_sample = 24'd0;
  logic        i_sample_valid = 1'b0;
  logic        o_sdo, o_sdo_t, o_ctrl_wr, o_rd_done, o_overrun;
  logic [15:0] o_ctrl_reg;

  int total = 0, bad = 0;

  // reference model state
  logic        m_rdy = 1'b0, m_ovr = 1'b0;
  logic [23:0] m_pending = 24'd0;
  logic [15:0] m_ctrl = 16'h0000;
  int          exp_rd_done = 0, exp_ovr = 0;
  logic [23:0] exp_q[$], got_q[$];
  logic [15:0] exp_ctrl_q[$];

  ad7124_responder #(.ID_VALUE(ID), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .resetn(resetn), .i_sclk(i_sclk), .i_cs(i_cs), .i_sdi(i_sdi),
    .o_sdo(o_sdo), .o_sdo_t(o_sdo_t), .i_sample(i_sample),
    .i_sample_valid(i_sample_valid), .o_ctrl_reg(o_ctrl_reg),
    .o_ctrl_wr(o_ctrl_wr), .o_rd_done(o_rd_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic int m_width(input logic [5:0] a);
    case (a)
      6'h01:   return 16;
      6'h02:   return 24;
      default: return 8;
    endcase
  endfunction

  function automatic void m_sample(input logic [23:0] v);
    if (m_rdy) begin
      exp_ovr++;
      m_ovr = 1'b1;
    end
    m_pending = v;
    m_rdy = 1'b1;
  endfunction

  // Right-aligned value a register read returns, with its side effects.
  function automatic logic [23:0] m_read(input logic [5:0] a);
    logic [23:0] v;
    case (a)
      6'h00: begin v = {16'h0000, ~m_rdy, m_ovr, 6'b000000}; m_ovr = 1'b0; end
      6'h01: v = {8'h00, m_ctrl};
      6'h02: begin v = m_pending; m_rdy = 1'b0; exp_rd_done++; end
      6'h05: v = {16'h0000, ID};
      default: v = 24'h000000;
    endcase
    return v;
  endfunction

  task automatic push_sample(input logic [23:0] v);
    m_sample(v);
    i_sample = v;
    i_sample_valid = 1'b1;
    @(negedge clk);
    i_sample_valid = 1'b0;
  endtask

  // One SPI bit: fall + drive MOSI, then rise + sample MISO. Optionally
  // strobes a sample on the clk cycle where this rise is decoded.
  task automatic spi_bit(input logic mosi, input logic inject, input logic [23:0] inj_val,
                         output logic miso);
    i_sclk = 1'b0;
    i_sdi = mosi;
    repeat (H) @(negedge clk);
    i_sclk = 1'b1;
    miso = o_sdo;
    if (inject) begin
      repeat (SYNC) @(negedge clk);
      i_sample = inj_val;
      i_sample_valid = 1'b1;
      @(negedge clk);
      i_sample_valid = 1'b0;
      repeat (H - SYNC - 1) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int nbits, input logic [23:0] wdata,
                         input logic inject, input logic [23:0] inj_val,
                         output logic [23:0] rdata);
    logic b;
    i_cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], inject && (i == 7), inj_val, b);
    rdata = 24'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(wdata[nbits-1-i], 1'b0, 24'd0, b);
      rdata = {rdata[22:0], b};
    end
    repeat (H) @(negedge clk);
    i_cs = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic do_read(input logic [5:0] a);
    logic [23:0] e, g;
    e = m_read(a);
    exp_q.push_back(e);
    spi_txn({2'b01, a}, m_width(a), 24'd0, 1'b0, 24'd0, g);
    got_q.push_back(g);
  endtask

  task automatic do_read_inj(input logic [23:0] inj);
    logic [23:0] e, g;
    e = m_read(6'h02);
    m_sample(inj);
    exp_q.push_back(e);
    spi_txn(8'h42, 24, 24'd0, 1'b1, inj, g);
    got_q.push_back(g);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [23:0] v);
    logic [23:0] g;
    if (a == 6'h01) begin
      m_ctrl = v[15:0];
      exp_ctrl_q.push_back(v[15:0]);
    end
    spi_txn({2'b00, a}, m_width(a), v, 1'b0, 24'd0, g);
  endtask

  // Monitor: scores every DUT pulse and every captured MISO word.
  always @(negedge clk) begin
    if (resetn) begin
      if (o_ctrl_wr) begin
        if (exp_ctrl_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ctrl_wr_pulse: got pulse want none (ctrl_reg %h)", o_ctrl_reg);
        end else begin
          check("ctrl_wr_value", {8'h00, o_ctrl_reg}, {8'h00, exp_ctrl_q.pop_front()});
        end
      end
      if (o_rd_done) begin
        total++;
        if (exp_rd_done == 0) begin
          bad++;
          $display("FAIL rd_done_pulse: got pulse want none");
        end else begin
          exp_rd_done--;
        end
      end
      if (o_overrun) begin
        total++;
        if (exp_ovr == 0) begin
          bad++;
          $display("FAIL overrun_pulse: got pulse want none");
        end else begin
          exp_ovr--;
        end
      end
      if (got_q.size() > 0) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL miso_word: got %h want no word", got_q.pop_front());
        end else begin
          check("miso_word", got_q.pop_front(), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic        e1, b;
    logic [23:0] g, r24;
    logic [5:0]  a;
    int          op;

    // reset values
    repeat (4) @(negedge clk);
    check("rst_sdo", o_sdo, 1'b1);
    check("rst_sdo_t", o_sdo_t, 1'b1);
    check("rst_ctrl", o_ctrl_reg, 16'h0000);
    check("rst_pulses", {o_ctrl_wr, o_rd_done, o_overrun}, 3'b000);
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    // RDY line in CMD: high before a sample, low the cycle after one arrives
    i_cs = 1'b0;
    repeat (2*H) @(negedge clk);
    e1 = ~m_rdy;
    check("cmd_rdy_before", o_sdo, e1);
    check("sdo_t_cs_low", o_sdo_t, 1'b0);
    push_sample(24'hA5C3F0);
    e1 = ~m_rdy;
    check("cmd_rdy_after", o_sdo, e1);
    i_cs = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("sdo_t_cs_high", o_sdo_t, 1'b1);
    repeat (2*H) @(negedge clk);

    // data read then status
    do_read(6'h02);
    do_read(6'h00);

    // control write and read back
    do_write(6'h01, 24'h000480);
    do_read(6'h01);

    // overrun sequence
    push_sample(24'h000001);
    push_sample(24'h000002);
    do_read(6'h02);
    do_read(6'h00);
    do_read(6'h00);

    // aborted write: 10 of 16 data bits
    spi_txn(8'h01, 10, 24'h0002AA, 1'b0, 24'd0, g);
    check("abort_sdo_t", o_sdo_t, 1'b1);
    check("abort_ctrl", o_ctrl_reg, m_ctrl);
    do_read(6'h05);

    // WEN=1 command: MISO stays high for the rest of cs-low
    exp_q.push_back(24'hFFFFFF);
    spi_txn(8'hC2, 24, 24'd0, 1'b0, 24'd0, g);
    got_q.push_back(g);

    // sample arriving on the decode cycle of a data read
    push_sample(24'h111111);
    do_read_inj(24'h222222);
    do_read(6'h00);
    do_read(6'h02);

    // reset mid-transfer with cs held low: no transaction until cs cycles
    push_sample(24'h0BEEF0);
    i_cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 12; i++) spi_bit(i[0], 1'b0, 24'd0, b);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    m_rdy = 1'b0; m_ovr = 1'b0; m_pending = 24'd0; m_ctrl = 16'h0000;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_ctrl", o_ctrl_reg, m_ctrl);
    push_sample(24'h5A5A5A);
    check("midrst_idle_sdo", o_sdo, 1'b1);
    r24 = 24'd0;
    for (int i = 0; i < 8; i++) spi_bit(r24[7-i] | (i == 1) | (i == 6), 1'b0, 24'd0, b);
    for (int i = 0; i < 24; i++) begin
      spi_bit(1'b0, 1'b0, 24'd0, b);
      r24 = {r24[22:0], b};
    end
    check("midrst_no_txn", r24, 24'hFFFFFF);
    i_cs = 1'b1;
    repeat (2*H) @(negedge clk);
    do_read(6'h02);

    // randomized traffic
    for (int n = 0; n < 26; n++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0: push_sample(24'($urandom));
        1: do_read(6'h02);
        2: do_read(6'h00);
        3: do_write(6'h01, {8'h00, 16'($urandom)});
        4: do_read(6'h01);
        5: do_read(6'($urandom_range(0, 63)));
        default: begin
          a = 6'($urandom_range(0, 63));
          if (a == 6'h01) a = 6'h03;
          do_write(a, 24'($urandom));
        end
      endcase
      repeat (3) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("final_ctrl", o_ctrl_reg, m_ctrl);
    check("rd_done_missing", 24'(exp_rd_done), 24'd0);
    check("overrun_missing", 24'(exp_ovr), 24'd0);
    check("ctrl_wr_missing", 24'(exp_ctrl_q.size()), 24'd0);
    check("miso_words_left", 24'(exp_q.size()), 24'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
